// File: rtl/lr_car_detector_pkg.sv
// Shared definitions for the local-road car detector: service FSM encoding and default sizing,
// reused by the traffic light controller bench.
package lr_car_detector_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } svc_state_t;

  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_DEPART_CYCLES = 10;
  localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/lr_car_detector_debounce_sync.sv
// Two-flop synchronizer plus run-length debouncer for the loop sensor.
// stable changes only after DEB_CYCLES consecutive differing samples; rise pulses one cycle per debounced rising edge.
module lr_car_detector_debounce_sync #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_raw,
  output logic stable,
  output logic rise
);

  localparam int DW = $clog2(DEB_CYCLES);

  logic          sync1;
  logic          s;
  logic          stable_d;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync1    <= sensor_raw;
      s        <= sync1;
      stable_d <= stable;
      // Any sample agreeing with the current level aborts a pending change.
      if (s == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        stable  <= s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/lr_car_detector.sv
// Local-road car detector: counts debounced arrivals and retires one car per DEPART_CYCLES green cycles.
// lr_has_car and car_count come straight from registers; overflow is sticky until reset.
module lr_car_detector
  import lr_car_detector_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int DEPART_CYCLES = DEF_DEPART_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic             lr_green,
  output logic             lr_has_car,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow
);

  localparam int               DPW     = $clog2(DEPART_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  svc_state_t       state, state_next;
  logic [DPW-1:0]   dep_cnt, dep_next;
  logic [CNT_W-1:0] count_next;
  logic             stable;
  logic             arrive;
  logic             depart;
  logic             ovf_set;

  lr_car_detector_debounce_sync #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .sensor_raw(sensor_raw),
    .stable    (stable),
    .rise      (arrive)
  );

  always_comb begin
    count_next = car_count;
    ovf_set    = 1'b0;
    depart     = (state == SERVE) && lr_green && (dep_cnt == DPW'(DEPART_CYCLES - 1));
    if (arrive && !depart) begin
      if (car_count == CNT_MAX) ovf_set = 1'b1;
      else                      count_next = car_count + CNT_W'(1);
    end else if (depart && !arrive) begin
      count_next = car_count - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    dep_next   = dep_cnt;
    case (state)
      IDLE: begin
        dep_next = '0;
        // The entry cycle is itself a green cycle, so the timer starts at one.
        if (lr_green && (car_count != '0)) begin
          state_next = SERVE;
          dep_next   = DPW'(1);
        end
      end
      SERVE: begin
        if (!lr_green || (count_next == '0)) begin
          state_next = IDLE;
          dep_next   = '0;
        end else if (depart) begin
          dep_next = '0;
        end else begin
          dep_next = dep_cnt + DPW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        dep_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dep_cnt   <= '0;
      car_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      dep_cnt   <= dep_next;
      car_count <= count_next;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  assign lr_has_car = (car_count != '0);

endmodule

// File: tb/tb_lr_car_detector.sv
// Randomized and directed bench for lr_car_detector against a queue-level behavioural model.
module tb_lr_car_detector;

  localparam int DEB  = 4;
  localparam int DEP  = 10;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sensor_raw = 1'b0;
  logic          lr_green = 1'b0;
  logic          lr_has_car;
  logic [CW-1:0] car_count;
  logic          overflow;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  lr_car_detector #(.DEB_CYCLES(DEB), .DEPART_CYCLES(DEP), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sensor_raw(sensor_raw),
    .lr_green  (lr_green),
    .lr_has_car(lr_has_car),
    .car_count (car_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: sensor seen through a two-sample delay, a level flips after DEB
  // consecutive disagreeing samples, a rise is counted one edge later, and a car
  // leaves after every DEP-th consecutive green cycle spent with a non-empty queue.
  int m_sync1, m_sync2, m_stable, m_stable_d, m_run;
  int m_count, m_timer, m_ovf;
  int m_arrive, m_active, m_dep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1 = 0; m_sync2 = 0; m_stable = 0; m_stable_d = 0; m_run = 0;
      m_count = 0; m_timer = 0; m_ovf = 0;
    end else begin
      m_arrive = (m_stable == 1 && m_stable_d == 0) ? 1 : 0;
      m_active = (lr_green && m_count != 0) ? 1 : 0;
      m_dep    = (m_active == 1 && m_timer + 1 == DEP) ? 1 : 0;
      if (m_arrive == 1 && m_dep == 0) begin
        if (m_count == MAXC) m_ovf = 1;
        else m_count = m_count + 1;
      end else if (m_dep == 1 && m_arrive == 0) begin
        m_count = m_count - 1;
      end
      m_timer = (m_active == 0 || m_dep == 1) ? 0 : m_timer + 1;
      m_stable_d = m_stable;
      m_run = (m_sync2 != m_stable) ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_stable = m_sync2;
        m_run = 0;
      end
      m_sync2 = m_sync1;
      m_sync1 = int'(sensor_raw);
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("model_count", int'(car_count), m_count);
      chk("model_has_car", int'(lr_has_car), (m_count != 0) ? 1 : 0);
      chk("model_overflow", int'(overflow), m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold);
    sensor_raw = 1'b1;
    tick(hold);
    sensor_raw = 1'b0;
    tick(10);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    sensor_raw = 1'b0;
    lr_green = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    run_chk = 1'b1;
    chk("reset_count", int'(car_count), 0);
    chk("reset_has_car", int'(lr_has_car), 0);
    chk("reset_overflow", int'(overflow), 0);

    // Clean arrival: first sampled high at edge 1, counted at edge 7.
    sensor_raw = 1'b1;
    tick(6);
    chk("lat_edge6", int'(car_count), 0);
    tick(1);
    chk("lat_edge7", int'(car_count), 1);
    chk("lat_has_car", int'(lr_has_car), 1);
    tick(13);
    chk("held_no_recount", int'(car_count), 1);
    sensor_raw = 1'b0;
    tick(10);
    press(6);
    chk("repress", int'(car_count), 2);

    // Glitch rejection, then the shortest accepted pulse.
    press(3);
    chk("glitch3", int'(car_count), 2);
    press(4);
    chk("pulse4", int'(car_count), 3);

    // Asynchronous reset mid-cycle with a non-empty queue.
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(car_count), 0);
    chk("async_rst_has_car", int'(lr_has_car), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    press(6);
    chk("post_rst_press", int'(car_count), 1);
    press(6);
    press(6);
    chk("svc_preload", int'(car_count), 3);

    // Service with green held.
    lr_green = 1'b1;
    tick(9);
    chk("svc_edge9", int'(car_count), 3);
    tick(1);
    chk("svc_edge10", int'(car_count), 2);
    tick(10);
    chk("svc_edge20", int'(car_count), 1);
    tick(10);
    chk("svc_edge30", int'(car_count), 0);
    chk("svc_empty_has_car", int'(lr_has_car), 0);
    lr_green = 1'b0;
    press(6);
    press(6);
    press(6);

    // Green dropped part way: partial time discarded.
    lr_green = 1'b1;
    tick(15);
    chk("partial_15", int'(car_count), 2);
    lr_green = 1'b0;
    tick(3);
    lr_green = 1'b1;
    tick(5);
    chk("restart_5", int'(car_count), 2);
    tick(5);
    chk("restart_10", int'(car_count), 1);
    lr_green = 1'b0;
    press(6);

    // Arrival and departure on the same edge.
    lr_green = 1'b1;
    tick(3);
    sensor_raw = 1'b1;
    tick(7);
    chk("simultaneous", int'(car_count), 2);
    sensor_raw = 1'b0;
    lr_green = 1'b0;
    tick(10);

    // Saturation.
    do_reset();
    for (int i = 0; i < 15; i++) press(6);
    chk("sat_15_count", int'(car_count), 15);
    chk("sat_15_ovf", int'(overflow), 0);
    press(6);
    chk("sat_16_count", int'(car_count), 15);
    chk("sat_16_ovf", int'(overflow), 1);
    lr_green = 1'b1;
    tick(10);
    chk("sat_depart", int'(car_count), 14);
    chk("sat_ovf_sticky", int'(overflow), 1);
    lr_green = 1'b0;

    // Random traffic with mixed glitches and green phases.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) sensor_raw = ~sensor_raw;
      if ($urandom_range(0, 39) == 0) lr_green = ~lr_green;
      tick(1);
    end

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lr_car_detector.md
Name: lr_car_detector

Overview:
Upstream conditioning stage for the traffic light controller. It takes the raw, noisy, asynchronous local-road loop-sensor signal and synchronizes and debounces it. It counts arriving cars and retires one queued car per fixed service interval while the local road is green. It drives lr_has_car (count non-zero) directly into the controller and consumes the controller's lr_light[2] (green) as lr_green.

Parameters:
DEB_CYCLES, 4, consecutive synchronized samples that must differ from the current debounced level before that level changes (>=2)
DEPART_CYCLES, 10, green cycles needed to retire one queued car (>=2)
CNT_W, 4, width of the car counter; maximum queue is 2^CNT_W-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
sensor_raw  input  1  raw loop-detector level, asynchronous, may glitch
lr_green  input  1  local-road green (controller lr_light[2])
lr_has_car  output  1  high while car_count != 0
car_count  output  CNT_W  cars currently queued on the local road
overflow  output  1  sticky; set when an arrival is dropped at saturation

Behaviour:
- Reset (async, rst_n=0): sync flops, debounced level, deb_cnt, dep_cnt and car_count all go to 0; FSM goes to IDLE; overflow=0; lr_has_car=0. No output glitch on release.
- Synchronizer: two flops on sensor_raw; the second flop's output is s.
- Debounce: if s == stable, deb_cnt<=0. Otherwise deb_cnt increments. When deb_cnt==DEB_CYCLES-1 and s != stable, stable<=s and deb_cnt<=0. Any sample equal to stable aborts the run.
- Arrival pulse: stable & ~stable_d, where stable_d is stable registered. Exactly one cycle per debounced rising edge. Falling edges are ignored.
- Latency: if sensor_raw is first sampled high at edge 1 and held, stable rises at edge DEB_CYCLES+2 and car_count increments at edge DEB_CYCLES+3 (edge 7 with defaults).
- Service FSM, 2 states:
  - IDLE: dep_cnt=0. Go to SERVE when lr_green=1 and car_count!=0.
  - SERVE: dep_cnt increments each cycle. When dep_cnt==DEPART_CYCLES-1, issue a one-cycle depart pulse and set dep_cnt<=0. Return to IDLE (dep_cnt<=0, no depart) when lr_green=0, or when car_count==0 after an update.
  - Partial service time is discarded when green drops.
- Count update, same edge:
  - arrive only: +1, saturating at 2^CNT_W-1. An arrival at saturation is dropped and sets overflow.
  - depart only: -1. Depart is never issued at 0.
  - arrive and depart together: unchanged.
- lr_has_car = (car_count != 0). It is derived from the register only, so it is glitch-free.
- overflow clears only on reset.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, SERVE=1'b1) and the default constants DEB_CYCLES, DEPART_CYCLES, CNT_W, so the controller bench can reuse them.
- One natural sub-module: debounce_sync (2-flop synchronizer + debounce counter). Outputs are the stable level and the rise pulse; parameter DEB_CYCLES. The counter and service FSM stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-count with car_count=3 -> all outputs 0 immediately, without waiting for a clock edge. After release, a sensor pulse is counted normally.
- Clean arrival: sensor_raw high from edge 1, held 20 cycles, lr_green=0 -> car_count 0->1 at edge 7, lr_has_car=1 from edge 7. No further increment while held; release and re-press -> count 2.
- Glitch rejection: sensor_raw high for 3 sampled cycles then low -> car_count stays 0, deb_cnt returns to 0. A 4-cycle high that survives sync -> counted once.
- Service: car_count=3, lr_green held high -> decrements at green edges 10, 20, 30. lr_has_car falls with the third decrement; FSM returns to IDLE. lr_green dropped at green edge 15 -> count stays 2, and the next green restarts the 10-cycle timer.
- Simultaneous: arrival pulse on the same edge as a depart with car_count=2 -> stays 2.
- Saturation: CNT_W=4, drive 16 debounced arrivals -> car_count=15, overflow=1 after the 16th. A later depart -> 14, overflow stays 1.
